// File: rtl/dl_rom_pkg.sv
// dl_rom_pkg: shared state encoding, download address width default and
// the lane-to-bit-offset helper for the packed download ROM.
package dl_rom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    FIN
  } dl_state_t;

  localparam int DLAW_DEF = 18;

  // Bit offset of byte lane 'lane' inside a word of 'bpw' bytes.
  function automatic int lane_pos(input int lane, input int bpw, input bit bigend);
    return bigend ? 8 * (bpw - 1 - lane) : 8 * lane;
  endfunction

endpackage

// File: rtl/dl_byte_packer.sv
// dl_byte_packer: filters the byte-serial download stream to the ROM window,
// packs lanes into words and drives a one-entry write stage toward memory.
// With DL_CHECKSUM_EN defined it also keeps a 16-bit sum of accepted bytes.
module dl_byte_packer
  import dl_rom_pkg::*;
#(
  parameter int AW     = 10,
  parameter int BPW    = 2,
  parameter int DLAW   = DLAW_DEF,
  parameter int BASE   = 0,
  parameter bit BIGEND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DLAW-1:0]   dlad,
  input  logic [7:0]        dldt,
  input  logic              dlen,
  input  logic              dlact,
`ifdef DL_CHECKSUM_EN
  output logic [15:0]       csum,
`endif
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [8*BPW-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DW = 8 * BPW;
  localparam int LW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LW-1:0] LAST = LW'(BPW - 1);
  localparam logic [DLAW:0] WIN_LO = (DLAW+1)'(BASE);
  localparam logic [DLAW:0] WIN_HI = (DLAW+1)'(BASE + BPW * (1 << AW));

  dl_state_t       state;
  logic            dlact_q;
  logic [LW-1:0]   expct;
  logic [DW-1:0]   acc;
  logic [AW-1:0]   acc_addr;

  logic [DLAW-1:0] off;
  logic [DLAW-1:0] quo;
  logic [DLAW-1:0] rem;
  logic [LW-1:0]   lane;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   placed;
  logic            hit;
  logic            in_order;
  logic            unused_bits;

  assign off    = dlad - DLAW'(BASE);
  assign quo    = off / DLAW'(BPW);
  assign rem    = off % DLAW'(BPW);
  assign lane   = rem[LW-1:0];
  assign waddr  = quo[AW-1:0];
  assign hit    = dlen && ({1'b0, dlad} >= WIN_LO) && ({1'b0, dlad} < WIN_HI);
  assign placed = DW'(dldt) << lane_pos(int'(lane), BPW, BIGEND);

  // A continuation lane must also belong to the word that lane 0 opened,
  // so a jump to another word's matching lane counts as out of order.
  assign in_order = (lane == expct) && ((expct == '0) || (waddr == acc_addr));

  assign unused_bits = ^{quo[DLAW-1:AW], rem[DLAW-1:LW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dlact_q  <= 1'b0;
      expct    <= '0;
      acc      <= '0;
      acc_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef DL_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      dlact_q <= dlact;
      wr_en   <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (dlact && !dlact_q) begin
            state <= FILL;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            expct <= '0;
            acc   <= '0;
`ifdef DL_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        FILL: begin
          if (hit) begin
`ifdef DL_CHECKSUM_EN
            csum <= csum + 16'(dldt);
`endif
            if (in_order) begin
              if (lane == LAST) begin
                wr_en   <= 1'b1;
                wr_addr <= waddr;
                wr_data <= acc | placed;
                acc     <= '0;
                expct   <= '0;
              end else begin
                acc   <= acc | placed;
                expct <= expct + LW'(1);
                if (lane == '0) acc_addr <= waddr;
              end
            end else begin
              err <= 1'b1;
              if (lane == '0) begin
                acc      <= placed;
                acc_addr <= waddr;
                expct    <= LW'(1);
              end else begin
                acc   <= '0;
                expct <= '0;
              end
            end
          end
          if (!dlact) state <= FLUSH;
        end
        FLUSH: begin
          // Any stage loaded on the previous edge commits on this one.
          if (expct != '0) begin
            wr_en   <= 1'b1;
            wr_addr <= acc_addr;
            wr_data <= acc;
            acc     <= '0;
            expct   <= '0;
          end else begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dl_packed_rom.sv
// dl_packed_rom: download-writable ROM of 2**AW words of BPW bytes with a
// registered read-first port. DL_CHECKSUM_EN adds the CSUM output.
module dl_packed_rom
  import dl_rom_pkg::*;
#(
  parameter int AW     = 10,
  parameter int BPW    = 2,
  parameter int DLAW   = DLAW_DEF,
  parameter int BASE   = 0,
  parameter bit BIGEND = 1
) (
  input  logic              CL,
  input  logic              RST_N,
  input  logic [AW-1:0]     AD,
  output logic [8*BPW-1:0]  DO,
  input  logic [DLAW-1:0]   DLAD,
  input  logic [7:0]        DLDT,
  input  logic              DLEN,
  input  logic              DLACT,
`ifdef DL_CHECKSUM_EN
  output logic [15:0]       CSUM,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int DW = 8 * BPW;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  dl_byte_packer #(
    .AW    (AW),
    .BPW   (BPW),
    .DLAW  (DLAW),
    .BASE  (BASE),
    .BIGEND(BIGEND)
  ) u_packer (
    .clk    (CL),
    .rst_n  (RST_N),
    .dlad   (DLAD),
    .dldt   (DLDT),
    .dlen   (DLEN),
    .dlact  (DLACT),
`ifdef DL_CHECKSUM_EN
    .csum   (CSUM),
`endif
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (BUSY),
    .done   (DONE),
    .err    (ERR)
  );

  // Contents survive reset so committed words outlive an aborted session.
  always_ff @(posedge CL) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) DO <= '0;
    else        DO <= mem[AD];
  end

endmodule

// File: tb/tb_dl_packed_rom.sv
// tb_dl_packed_rom: drives one download stream into a big-endian and a
// little-endian ROM instance; a scoreboard monitor checks reads and status.
module tb_dl_packed_rom;

  typedef struct {
    string       name;
    bit          chk_do;
    logic [15:0] be;
    logic [15:0] le;
    logic [2:0]  stat;
  } exp_t;

  logic        cl = 1'b0;
  logic        rst_n;
  logic [3:0]  ad;
  logic [17:0] dlad;
  logic [7:0]  dldt;
  logic        dlen;
  logic        dlact;
  logic [15:0] do_be, do_le;
  logic        busy_be, done_be, err_be;
  logic        busy_le, done_le, err_le;
`ifdef DL_CHECKSUM_EN
  logic [15:0] csum_be, csum_le;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   req = 1'b0;

  always #5 cl = ~cl;

  dl_packed_rom #(.AW(4), .BPW(2), .DLAW(18), .BASE('h100), .BIGEND(1)) u_be (
    .CL(cl), .RST_N(rst_n), .AD(ad), .DO(do_be),
    .DLAD(dlad), .DLDT(dldt), .DLEN(dlen), .DLACT(dlact),
`ifdef DL_CHECKSUM_EN
    .CSUM(csum_be),
`endif
    .BUSY(busy_be), .DONE(done_be), .ERR(err_be)
  );

  dl_packed_rom #(.AW(4), .BPW(2), .DLAW(18), .BASE('h100), .BIGEND(0)) u_le (
    .CL(cl), .RST_N(rst_n), .AD(ad), .DO(do_le),
    .DLAD(dlad), .DLDT(dldt), .DLEN(dlen), .DLACT(dlact),
`ifdef DL_CHECKSUM_EN
    .CSUM(csum_le),
`endif
    .BUSY(busy_le), .DONE(done_le), .ERR(err_le)
  );

  task automatic applyStimulus(input logic [17:0] a, input logic [7:0] d);
    dlad = a;
    dldt = d;
    dlen = 1'b1;
    @(negedge cl);
    dlen = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] a, input bit cd,
                             input logic [15:0] be, input logic [15:0] le,
                             input logic [2:0] st);
    exp_t e;
    e.name = name; e.chk_do = cd; e.be = be; e.le = le; e.stat = st;
    sb.push_back(e);
    ad  = a;
    req = 1'b1;
    @(negedge cl);
    req = 1'b0;
  endtask

  task automatic startSession();
    dlact = 1'b1;
    @(negedge cl);
  endtask

  task automatic endSession();
    dlen  = 1'b0;
    dlact = 1'b0;
    repeat (4) @(negedge cl);
  endtask

  // Monitor: a request seen at a rising edge is compared half a cycle later.
  initial begin
    bit   pending;
    exp_t e;
    forever begin
      @(posedge cl);
      pending = req;
      @(negedge cl);
      if (pending) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_empty: output presented with no expectation queued");
        end else begin
          e = sb.pop_front();
          if ({busy_be, done_be, err_be} !== e.stat || {busy_le, done_le, err_le} !== e.stat ||
              (e.chk_do && (do_be !== e.be || do_le !== e.le))) begin
            errors++;
            $display("[TB] FAIL %s: DO be=%h le=%h status(busy,done,err) be=%b le=%b, required DO be=%h le=%h status=%b%s",
                     e.name, do_be, do_le, {busy_be, done_be, err_be}, {busy_le, done_le, err_le},
                     e.be, e.le, e.stat, e.chk_do ? "" : " (DO not compared)");
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; dlact = 1'b0; dlen = 1'b0; ad = '0; dlad = '0; dldt = '0;
    repeat (2) @(negedge cl);
    checkOutput("reset_state", 4'd0, 1'b1, 16'h0000, 16'h0000, 3'b000);
    rst_n = 1'b1;
    @(negedge cl);

    // Four consecutive in-window bytes fill words 0 and 1.
    startSession();
    checkOutput("busy_in_fill", 4'd0, 1'b0, 16'h0000, 16'h0000, 3'b100);
    applyStimulus(18'h100, 8'hAA);
    applyStimulus(18'h101, 8'hBB);
    applyStimulus(18'h102, 8'hCC);
    applyStimulus(18'h103, 8'hDD);
    endSession();
    checkOutput("s1_mem0", 4'd0, 1'b1, 16'hAABB, 16'hBBAA, 3'b010);
    checkOutput("s1_mem1", 4'd1, 1'b1, 16'hCCDD, 16'hDDCC, 3'b010);

    // Out-of-window bytes are ignored; a lone lane-0 byte is flushed.
    startSession();
    applyStimulus(18'h0FF, 8'h11);
    applyStimulus(18'h120, 8'h22);
    applyStimulus(18'h104, 8'h33);
    endSession();
    checkOutput("s3_flush_mem2", 4'd2, 1'b1, 16'h3300, 16'h0033, 3'b010);
    checkOutput("s3_mem0_kept", 4'd0, 1'b1, 16'hAABB, 16'hBBAA, 3'b010);

    // Lane-order error: EE belongs to word 1 while word 0 is open.
    startSession();
    applyStimulus(18'h100, 8'hAA);
    applyStimulus(18'h103, 8'hEE);
    applyStimulus(18'h104, 8'h12);
    applyStimulus(18'h105, 8'h34);
    applyStimulus(18'h106, 8'h77);
    applyStimulus(18'h107, 8'h88);
    endSession();
    checkOutput("s4_mem2", 4'd2, 1'b1, 16'h1234, 16'h3412, 3'b011);
    checkOutput("s4_mem0_kept", 4'd0, 1'b1, 16'hAABB, 16'hBBAA, 3'b011);
    checkOutput("s4_mem3", 4'd3, 1'b1, 16'h7788, 16'h8877, 3'b011);

    // New session clears ERR/DONE; reset mid-word aborts without commit.
    startSession();
    checkOutput("rise_clears_err", 4'd0, 1'b0, 16'h0000, 16'h0000, 3'b100);
    applyStimulus(18'h106, 8'h55);
    rst_n = 1'b0;
    dlact = 1'b0;
    checkOutput("mid_word_reset", 4'd3, 1'b1, 16'h0000, 16'h0000, 3'b000);
    rst_n = 1'b1;
    @(negedge cl);
    checkOutput("post_reset_mem3", 4'd3, 1'b1, 16'h7788, 16'h8877, 3'b000);
    checkOutput("post_reset_mem2", 4'd2, 1'b1, 16'h1234, 16'h3412, 3'b000);

    // Full word plus a trailing partial word.
    startSession();
    applyStimulus(18'h108, 8'hFF);
    applyStimulus(18'h109, 8'hFF);
    applyStimulus(18'h10A, 8'h02);
    endSession();
    checkOutput("s6_mem4", 4'd4, 1'b1, 16'hFFFF, 16'hFFFF, 3'b010);
    checkOutput("s6_mem5_flush", 4'd5, 1'b1, 16'h0200, 16'h0002, 3'b010);

`ifdef DL_CHECKSUM_EN
    checks++;
    if (csum_be !== 16'h0200 || csum_le !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL csum_sum: got be=%h le=%h, required 0200", csum_be, csum_le);
    end
    dlact = 1'b1;
    @(negedge cl);
    checks++;
    if (csum_be !== 16'h0000 || csum_le !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL csum_clear: got be=%h le=%h, required 0000", csum_be, csum_le);
    end
    dlact = 1'b0;
`endif

    repeat (2) @(negedge cl);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
